// File: rtl/cache_types.sv
// Shared cache-side types: line arbiter states, line/beat geometry and an address helper.
package cache_types;

    typedef enum logic [2:0] {
        ARB_IDLE,
        ARB_WR_BURST,
        ARB_RD_ISSUE,
        ARB_RD_WAIT,
        ARB_RESP
    } line_arb_state_t;

    localparam int LINE_BITS        = 256;
    localparam int BEAT_BITS        = 64;
    localparam int LINE_OFFSET_BITS = 5;

    function automatic logic [31:0] line_align(input logic [31:0] addr);
        return addr & ~((32'd1 << LINE_OFFSET_BITS) - 32'd1);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotate-priority picker: first pending index at or after rr_ptr, wrapping.
module rr_pick #(
    parameter int N     = 3,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     pending,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic             gnt_valid,
    output logic [IDX_W-1:0] gnt_idx
);

    localparam int SW = IDX_W + 1;

    logic [2*N-1:0] rotated;
    logic [SW-1:0]  sum;

    // rotated[k] is pending[(rr_ptr+k) mod N]; scanning k downward leaves the lowest k as winner
    always_comb begin
        rotated   = {pending, pending} >> rr_ptr;
        sum       = '0;
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rotated[k]) begin
                sum = {1'b0, rr_ptr} + SW'(k);
                if (sum >= SW'(N)) begin
                    sum = sum - SW'(N);
                end
                gnt_valid = 1'b1;
                gnt_idx   = sum[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/line_mem_arbiter.sv
// Round-robin arbiter sharing one 64-bit burst memory port among line-granularity requesters.
// Optional per-requester grant/wait counters are built when LINE_ARB_PERF_EN is defined.
module line_mem_arbiter
    import cache_types::*;
#(
    parameter int NUM_REQ = 3,
    parameter int BEATS   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ*32-1:0]      req_addr,
    input  logic [NUM_REQ-1:0]         req_read,
    input  logic [NUM_REQ-1:0]         req_write,
    input  logic [NUM_REQ*LINE_BITS-1:0] req_wdata,
    output logic [LINE_BITS-1:0]       req_rdata,
    output logic [NUM_REQ-1:0]         req_resp,
    output logic [31:0]                bmem_addr,
    output logic                       bmem_read,
    output logic                       bmem_write,
    output logic [BEAT_BITS-1:0]       bmem_wdata,
    input  logic                       bmem_ready,
    input  logic [31:0]                bmem_raddr,
    input  logic [BEAT_BITS-1:0]       bmem_rdata,
    input  logic                       bmem_rvalid
`ifdef LINE_ARB_PERF_EN
    ,
    output logic [NUM_REQ*32-1:0]      perf_grants,
    output logic [NUM_REQ*32-1:0]      perf_wait
`endif
);

    localparam int IDX_W  = $clog2(NUM_REQ);
    localparam int BEAT_W = $clog2(BEATS);

    if (BEATS != 4) begin : g_beats_check
        $error("line_mem_arbiter: BEATS must be 4 for 256-bit lines on a 64-bit port");
    end

    line_arb_state_t       state;
    logic [IDX_W-1:0]      gnt_q;
    logic [IDX_W-1:0]      rr_ptr_q;
    logic [BEAT_W-1:0]     beat_q;
    logic [31:0]           line_addr_q;
    logic [BEAT_BITS-1:0]  buf_q [BEATS];
    logic [LINE_BITS-1:0]  rdata_q;

    logic [NUM_REQ-1:0]    pending;
    logic                  pick_valid;
    logic [IDX_W-1:0]      pick_idx;
    logic [31:0]           addr_arr  [NUM_REQ];
    logic [LINE_BITS-1:0]  wline_arr [NUM_REQ];
    logic [LINE_BITS-1:0]  sel_line;
    logic [BEAT_BITS-1:0]  wbeat_arr [BEATS];
    logic [LINE_BITS-1:0]  line_next;
    logic                  beat_hit;
    logic                  last_beat;

    assign pending = req_read | req_write;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
        assign addr_arr[i]  = req_addr[i*32 +: 32];
        assign wline_arr[i] = req_wdata[i*LINE_BITS +: LINE_BITS];
    end

    rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .pending   (pending),
        .rr_ptr    (rr_ptr_q),
        .gnt_valid (pick_valid),
        .gnt_idx   (pick_idx)
    );

    // Write data is taken live from the granted requester; the line buffer view folds in the arriving beat
    assign sel_line = wline_arr[gnt_q];
    for (genvar b = 0; b < BEATS; b++) begin : g_beat
        assign wbeat_arr[b] = sel_line[b*BEAT_BITS +: BEAT_BITS];
        assign line_next[b*BEAT_BITS +: BEAT_BITS] =
            (beat_q == BEAT_W'(b)) ? bmem_rdata : buf_q[b];
    end

    assign beat_hit  = bmem_rvalid && (line_align(bmem_raddr) == line_addr_q);
    assign last_beat = (beat_q == BEAT_W'(BEATS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ARB_IDLE;
            gnt_q       <= '0;
            rr_ptr_q    <= '0;
            beat_q      <= '0;
            line_addr_q <= '0;
            rdata_q     <= '0;
            for (int b = 0; b < BEATS; b++) begin
                buf_q[b] <= '0;
            end
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (pick_valid) begin
                        gnt_q       <= pick_idx;
                        line_addr_q <= line_align(addr_arr[pick_idx]);
                        state       <= req_write[pick_idx] ? ARB_WR_BURST : ARB_RD_ISSUE;
                    end
                end
                ARB_WR_BURST: begin
                    if (bmem_ready) begin
                        if (last_beat) begin
                            beat_q <= '0;
                            state  <= ARB_RESP;
                        end else begin
                            beat_q <= beat_q + BEAT_W'(1);
                        end
                    end
                end
                ARB_RD_ISSUE: begin
                    if (bmem_ready) begin
                        state <= ARB_RD_WAIT;
                    end
                end
                ARB_RD_WAIT: begin
                    // The completed line is published to req_rdata only once all beats are in
                    if (beat_hit) begin
                        buf_q[beat_q] <= bmem_rdata;
                        if (last_beat) begin
                            beat_q  <= '0;
                            rdata_q <= line_next;
                            state   <= ARB_RESP;
                        end else begin
                            beat_q <= beat_q + BEAT_W'(1);
                        end
                    end
                end
                ARB_RESP: begin
                    rr_ptr_q <= (gnt_q == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_q + IDX_W'(1);
                    state    <= ARB_IDLE;
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    assign bmem_read  = (state == ARB_RD_ISSUE);
    assign bmem_write = (state == ARB_WR_BURST);
    assign bmem_addr  = (bmem_read || bmem_write) ? line_addr_q : '0;
    assign bmem_wdata = bmem_write ? wbeat_arr[beat_q] : '0;
    assign req_resp   = (state == ARB_RESP) ? (NUM_REQ'(1) << gnt_q) : '0;
    assign req_rdata  = rdata_q;

`ifdef LINE_ARB_PERF_EN
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_perf
        logic        grant_now;
        logic        granted;
        logic [31:0] grants_q;
        logic [31:0] wait_q;

        assign grant_now = (state == ARB_IDLE) && pick_valid && (pick_idx == IDX_W'(i));
        assign granted   = (state == ARB_IDLE) ? grant_now : (gnt_q == IDX_W'(i));

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                grants_q <= '0;
                wait_q   <= '0;
            end else begin
                if (grant_now && (grants_q != '1)) begin
                    grants_q <= grants_q + 32'd1;
                end
                if (pending[i] && !granted && (wait_q != '1)) begin
                    wait_q <= wait_q + 32'd1;
                end
            end
        end

        assign perf_grants[i*32 +: 32] = grants_q;
        assign perf_wait[i*32 +: 32]   = wait_q;
    end
`endif

endmodule

// File: tb/tb_line_mem_arbiter.sv
// Directed self-checking bench for line_mem_arbiter (perf counters checked when LINE_ARB_PERF_EN is defined).
module tb_line_mem_arbiter;

    logic         clk;
    logic         rst;
    logic [95:0]  req_addr;
    logic [2:0]   req_read;
    logic [2:0]   req_write;
    logic [767:0] req_wdata;
    logic [255:0] req_rdata;
    logic [2:0]   req_resp;
    logic [31:0]  bmem_addr;
    logic         bmem_read;
    logic         bmem_write;
    logic [63:0]  bmem_wdata;
    logic         bmem_ready;
    logic [31:0]  bmem_raddr;
    logic [63:0]  bmem_rdata;
    logic         bmem_rvalid;
`ifdef LINE_ARB_PERF_EN
    logic [95:0]  perf_grants;
    logic [95:0]  perf_wait;
`endif

    int total = 0;
    int bad   = 0;

    localparam logic [63:0] BEAT_A = 64'hAAAA_0000_0000_0001;
    localparam logic [63:0] BEAT_B = 64'hBBBB_0000_0000_0002;
    localparam logic [63:0] BEAT_C = 64'hCCCC_0000_0000_0003;
    localparam logic [63:0] BEAT_D = 64'hDDDD_0000_0000_0004;
    localparam logic [63:0] WR0    = 64'h0101_0101_0101_0101;
    localparam logic [63:0] WR1    = 64'h0202_0202_0202_0202;
    localparam logic [63:0] WR2    = 64'h0303_0303_0303_0303;
    localparam logic [63:0] WR3    = 64'h0404_0404_0404_0404;

    logic [255:0] line1;

    line_mem_arbiter #(
        .NUM_REQ (3),
        .BEATS   (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
`ifdef LINE_ARB_PERF_EN
        .perf_grants (perf_grants),
        .perf_wait   (perf_wait),
`endif
        .req_addr    (req_addr),
        .req_read    (req_read),
        .req_write   (req_write),
        .req_wdata   (req_wdata),
        .req_rdata   (req_rdata),
        .req_resp    (req_resp),
        .bmem_addr   (bmem_addr),
        .bmem_read   (bmem_read),
        .bmem_write  (bmem_write),
        .bmem_wdata  (bmem_wdata),
        .bmem_ready  (bmem_ready),
        .bmem_raddr  (bmem_raddr),
        .bmem_rdata  (bmem_rdata),
        .bmem_rvalid (bmem_rvalid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] rd, input logic [2:0] wr, input logic rdy);
        req_read   = rd;
        req_write  = wr;
        bmem_ready = rdy;
    endtask

    // Drive one returning beat for exactly one clock edge
    task automatic sendBeat(input logic [31:0] raddr, input logic [63:0] data);
        bmem_rvalid = 1'b1;
        bmem_raddr  = raddr;
        bmem_rdata  = data;
        @(negedge clk);
        bmem_rvalid = 1'b0;
        bmem_raddr  = '0;
        bmem_rdata  = '0;
    endtask

    function automatic logic [63:0] beatData(input logic [31:0] addr, input int b);
        return {addr, 16'hB00B, 16'(b)};
    endfunction

    // Act as memory for one read: wait for the issue, return four beats, then check the completion
    task automatic serveRead(input int idx, input logic [31:0] addr);
        int n;
        logic [255:0] expLine;
        n = 0;
        while (bmem_read !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("rd_issue", {255'd0, bmem_read}, 256'd1);
        checkOutput("rd_addr", {224'd0, bmem_addr}, {224'd0, addr});
        @(negedge clk);
        expLine = '0;
        for (int b = 0; b < 4; b++) begin
            expLine[b*64 +: 64] = beatData(addr, b);
            sendBeat(addr, beatData(addr, b));
        end
        checkOutput("rd_resp", {253'd0, req_resp}, {253'd0, 3'(1 << idx)});
        checkOutput("rd_data", req_rdata, expLine);
    endtask

    initial begin
        rst         = 1'b1;
        req_addr    = '0;
        req_wdata   = '0;
        bmem_raddr  = '0;
        bmem_rdata  = '0;
        bmem_rvalid = 1'b0;
        applyStimulus(3'b000, 3'b000, 1'b0);
        line1 = {BEAT_D, BEAT_C, BEAT_B, BEAT_A};

        @(negedge clk);
        @(negedge clk);
        checkOutput("reset_bmem", {157'd0, bmem_read, bmem_write, bmem_addr, bmem_wdata}, 256'd0);
        checkOutput("reset_resp", {253'd0, req_resp}, 256'd0);
        checkOutput("reset_rdata", req_rdata, 256'd0);
        rst = 1'b0;

        // Stray beat while idle must not touch anything
        @(negedge clk);
        sendBeat(32'hDEAD_0000, 64'hFFFF_FFFF_FFFF_FFFF);
        checkOutput("idle_stray_read", {255'd0, bmem_read}, 256'd0);
        checkOutput("idle_stray_rdata", req_rdata, 256'd0);

        // Single read from requester 1 with a stray beat mid-burst
        $display("[TB] read from requester 1");
        req_addr[32 +: 32] = 32'h1000_0044;
        applyStimulus(3'b010, 3'b000, 1'b1);
        @(negedge clk);
        checkOutput("rd1_issue", {255'd0, bmem_read}, 256'd1);
        checkOutput("rd1_addr", {224'd0, bmem_addr}, {224'd0, 32'h1000_0040});
        checkOutput("rd1_nowrite", {255'd0, bmem_write}, 256'd0);
        @(negedge clk);
        checkOutput("rd1_wait_read", {255'd0, bmem_read}, 256'd0);
        sendBeat(32'h1000_0040, BEAT_A);
        sendBeat(32'h1000_0040, BEAT_B);
        sendBeat(32'hDEAD_0000, 64'h5555_5555_5555_5555);
        checkOutput("rd1_no_early_resp", {253'd0, req_resp}, 256'd0);
        sendBeat(32'h1000_0040, BEAT_C);
        sendBeat(32'h1000_0040, BEAT_D);
        checkOutput("rd1_resp", {253'd0, req_resp}, 256'd2);
        checkOutput("rd1_data", req_rdata, line1);
        applyStimulus(3'b000, 3'b000, 1'b1);
        @(negedge clk);
        checkOutput("rd1_resp_pulse", {253'd0, req_resp}, 256'd0);
        checkOutput("rd1_data_hold", req_rdata, line1);

        // Write (read also set, write wins) from requester 0 with two cycles of backpressure on beat 2
        $display("[TB] write from requester 0");
        req_addr[0 +: 32]    = 32'h2000_0013;
        req_wdata[0 +: 256]  = {WR3, WR2, WR1, WR0};
        applyStimulus(3'b001, 3'b001, 1'b1);
        @(negedge clk);
        checkOutput("wr_valid", {254'd0, bmem_write, bmem_read}, 256'd2);
        checkOutput("wr_addr", {224'd0, bmem_addr}, {224'd0, 32'h2000_0000});
        checkOutput("wr_beat0", {192'd0, bmem_wdata}, {192'd0, WR0});
        @(negedge clk);
        checkOutput("wr_beat1", {192'd0, bmem_wdata}, {192'd0, WR1});
        @(negedge clk);
        checkOutput("wr_beat2", {192'd0, bmem_wdata}, {192'd0, WR2});
        bmem_ready = 1'b0;
        @(negedge clk);
        checkOutput("wr_beat2_hold1", {192'd0, bmem_wdata}, {192'd0, WR2});
        @(negedge clk);
        checkOutput("wr_beat2_hold2", {192'd0, bmem_wdata}, {192'd0, WR2});
        bmem_ready = 1'b1;
        @(negedge clk);
        checkOutput("wr_beat3", {192'd0, bmem_wdata}, {192'd0, WR3});
        checkOutput("wr_no_early_resp", {253'd0, req_resp}, 256'd0);
        @(negedge clk);
        checkOutput("wr_resp", {253'd0, req_resp}, 256'd1);
        checkOutput("wr_write_low", {255'd0, bmem_write}, 256'd0);
        checkOutput("wr_rdata_kept", req_rdata, line1);
        applyStimulus(3'b000, 3'b000, 1'b1);
        @(negedge clk);
        checkOutput("wr_resp_pulse", {253'd0, req_resp}, 256'd0);

        // Reset in the middle of a read burst
        $display("[TB] reset mid-burst");
        req_addr[0 +: 32] = 32'h3000_0000;
        applyStimulus(3'b001, 3'b000, 1'b1);
        @(negedge clk);
        checkOutput("mid_issue", {255'd0, bmem_read}, 256'd1);
        @(negedge clk);
        sendBeat(32'h3000_0000, 64'hBAD0_BAD0_BAD0_BAD0);
        sendBeat(32'h3000_0000, 64'hBAD1_BAD1_BAD1_BAD1);
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_bmem", {157'd0, bmem_read, bmem_write, bmem_addr, bmem_wdata}, 256'd0);
        checkOutput("mid_rst_resp", {253'd0, req_resp}, 256'd0);
        checkOutput("mid_rst_rdata", req_rdata, 256'd0);
        req_addr[32 +: 32] = 32'h3100_0020;
        req_addr[64 +: 32] = 32'h3200_007F;
        applyStimulus(3'b111, 3'b000, 1'b1);
        @(negedge clk);
        rst = 1'b0;

        // Round robin from reset with every requester reading continuously
        $display("[TB] round robin");
        for (int k = 0; k < 6; k++) begin
            case (k % 3)
                0:       serveRead(0, 32'h3000_0000);
                1:       serveRead(1, 32'h3100_0020);
                default: serveRead(2, 32'h3200_0060);
            endcase
        end
        applyStimulus(3'b000, 3'b000, 1'b1);
        @(negedge clk);
        checkOutput("rr_idle_resp", {253'd0, req_resp}, 256'd0);

`ifdef LINE_ARB_PERF_EN
        // Requester 2 waits behind a write from requester 0 that stalls one cycle
        $display("[TB] perf counters");
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(3'b100, 3'b001, 1'b0);
        @(negedge clk);
        @(negedge clk);
        bmem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        checkOutput("perf_wr_resp", {253'd0, req_resp}, 256'd1);
        req_write = 3'b000;
        serveRead(2, 32'h3200_0060);
        req_read = 3'b000;
        @(negedge clk);
        checkOutput("perf_wait2", {224'd0, perf_wait[64 +: 32]}, 256'd7);
        checkOutput("perf_wait0", {224'd0, perf_wait[0 +: 32]}, 256'd0);
        checkOutput("perf_grants0", {224'd0, perf_grants[0 +: 32]}, 256'd1);
        checkOutput("perf_grants2", {224'd0, perf_grants[64 +: 32]}, 256'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
